// File: rtl/time_field_setter.sv
// time_field_setter: keypad-driven multi-field setting FSM with per-field range check and atomic commit.
// Optional inactivity abort is built when SETTER_TIMEOUT_EN is defined.
module time_field_setter #(
  parameter int NUM_FIELDS = 3,
  parameter int DIGITS_PER_FIELD = 2,
  parameter logic [8*NUM_FIELDS-1:0] FIELD_MAX_VEC = {8'd59, 8'd59, 8'd23},
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic clock,
  input  logic reset,
  input  logic en,
  input  logic sharp,
  input  logic star,
  input  logic digit_valid,
  input  logic [3:0] digit,
  output logic [NUM_FIELDS-1:0] field_en,
  output logic [7:0] cur_value,
  output logic [8*NUM_FIELDS-1:0] values_out,
  output logic completeSetting,
  output logic entry_err,
  output logic timeout
);
  localparam int IW = NUM_FIELDS > 1 ? $clog2(NUM_FIELDS) : 1;
  localparam logic [IW-1:0] LAST = IW'(NUM_FIELDS - 1);
  localparam logic [1:0] FULL = 2'(DIGITS_PER_FIELD);
  if (NUM_FIELDS < 1 || NUM_FIELDS > 8 || DIGITS_PER_FIELD < 1 || DIGITS_PER_FIELD > 3 ||
      TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_param
    $error("time_field_setter: parameter out of range");
  end
  typedef enum logic [1:0] {IDLE, ENTRY, DONE} state_t;
  state_t state, state_n;
  logic [IW-1:0] idx, idx_n;
  logic [1:0] cnt, cnt_n;
  logic [7:0] cur_n, max_val;
  logic [8*NUM_FIELDS-1:0] shadow, shadow_n;
  logic armed, armed_n, err_n, digit_ok;
`ifdef SETTER_TIMEOUT_EN
  logic [15:0] tcnt, tcnt_n;
  logic tmo_n, key;
`endif
  always_comb begin
    max_val = FIELD_MAX_VEC[8*idx +: 8];
    digit_ok = digit <= 4'd9 && cnt < FULL;
    state_n = state;
    idx_n = idx;
    cnt_n = cnt;
    cur_n = cur_value;
    shadow_n = shadow;
    err_n = 1'b0;
    // armed: a new session may only start after en has been seen low since the last commit
    armed_n = !en ? 1'b1 : state == DONE ? 1'b0 : armed;
`ifdef SETTER_TIMEOUT_EN
    tmo_n = 1'b0;
    key = digit_valid | sharp | star;
`endif
    case (state)
      IDLE: begin
        idx_n = '0;
        cnt_n = '0;
        cur_n = '0;
        shadow_n = '0;
        if (en && armed) state_n = ENTRY;
      end
      ENTRY: begin
        if (!en) begin
          state_n = IDLE;
          cnt_n = '0;
          cur_n = '0;
        end else if (sharp) begin
          if (cnt == '0) err_n = 1'b1;
          else begin
            cnt_n = '0;
            cur_n = '0;
            if (cur_value > max_val) err_n = 1'b1;
            else begin
              shadow_n[8*idx +: 8] = cur_value;
              if (idx == LAST) state_n = DONE;
              else idx_n = idx + 1'b1;
            end
          end
        end else if (star) begin
          // stepping back loads the committed value as a full field; a rejected sharp clears it
          if (idx != '0) begin
            idx_n = idx - 1'b1;
            cur_n = shadow[8*idx_n +: 8];
            cnt_n = FULL;
          end
        end else if (digit_valid) begin
          if (digit_ok) begin
            cur_n = cur_value * 8'd10 + {4'd0, digit};
            cnt_n = cnt + 2'd1;
          end else err_n = 1'b1;
        end
`ifdef SETTER_TIMEOUT_EN
        else if (tcnt == 16'(TIMEOUT_CYCLES - 1)) begin
          state_n = IDLE;
          tmo_n = 1'b1;
          armed_n = 1'b0;
          cnt_n = '0;
          cur_n = '0;
        end
`endif
      end
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
`ifdef SETTER_TIMEOUT_EN
    tcnt_n = (state == ENTRY && state_n == ENTRY && !key) ? tcnt + 16'd1 : '0;
`endif
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      idx <= '0;
      cnt <= '0;
      cur_value <= '0;
      shadow <= '0;
      values_out <= '0;
      field_en <= '0;
      completeSetting <= 1'b0;
      entry_err <= 1'b0;
      armed <= 1'b1;
    end else begin
      state <= state_n;
      idx <= idx_n;
      cnt <= cnt_n;
      cur_value <= cur_n;
      shadow <= shadow_n;
      armed <= armed_n;
      field_en <= state_n == ENTRY ? NUM_FIELDS'(1) << idx_n : '0;
      completeSetting <= state == DONE;
      if (state == DONE) values_out <= shadow;
      entry_err <= err_n;
    end
  end
`ifdef SETTER_TIMEOUT_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      tcnt <= '0;
      timeout <= 1'b0;
    end else begin
      tcnt <= tcnt_n;
      timeout <= tmo_n;
    end
  end
`else
  assign timeout = 1'b0;
`endif
endmodule
